// File: rtl/fp32_normalize_round.sv
// fp32_normalize_round: normalise, round-to-nearest-even and pack the Add32F raw sum into IEEE754 single.
module fp32_normalize_round #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float,
  output logic        out_inexact,
  output logic        out_overflow
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, state_n;
  logic sign, sign_n;
  logic [8:0] exp_q, exp_n;
  logic [27:0] mant, mant_n;
  logic [31:0] float_n;
  logic inexact_n, overflow_n;
  logic [8:0] lz, kc, k, re;
  logic inc;
  logic [24:0] m25;
  logic [23:0] m24;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    lz = 9'd27;
    for (int i = 0; i <= 26; i++) if (mant[i]) lz = 9'(26 - i);
    kc = (lz < 9'(SHIFT_STEP)) ? lz : 9'(SHIFT_STEP);
    k = (kc < exp_q - 9'd1) ? kc : exp_q - 9'd1;
  end
  // Round-to-nearest-even on the 24 significant bits; a carry out bumps the exponent.
  always_comb begin
    inc = mant[2] & (mant[1] | mant[0] | mant[3]);
    m25 = {1'b0, mant[26:3]} + {24'd0, inc};
    m24 = m25[24] ? m25[24:1] : m25[23:0];
    re = exp_q + {8'd0, m25[24]};
  end
  always_comb begin
    state_n = state;
    sign_n = sign;
    exp_n = exp_q;
    mant_n = mant;
    float_n = out_float;
    inexact_n = out_inexact;
    overflow_n = out_overflow;
    case (state)
      IDLE: if (in_valid) begin
        sign_n = in_sign;
        exp_n = {1'b0, in_exp};
        mant_n = in_mant;
        if (in_mant == 28'd0) begin
          state_n = DONE;
          float_n = {in_sign, 31'd0};
          inexact_n = 1'b0;
          overflow_n = 1'b0;
        end else if (in_mant[27]) begin
          mant_n = {1'b0, in_mant[27:2], in_mant[1] | in_mant[0]};
          exp_n = {1'b0, in_exp} + 9'd1;
          state_n = ROUND;
        end else state_n = in_mant[26] ? ROUND : NORM;
      end
      NORM: begin
        mant_n = mant << k;
        exp_n = exp_q - k;
        state_n = (mant_n[26] || exp_n == 9'd1) ? ROUND : NORM;
      end
      ROUND: begin
        state_n = DONE;
        inexact_n = |mant[2:0];
        overflow_n = re >= 9'd255;
        float_n = (re >= 9'd255) ? {sign, 8'hFF, 23'd0} : {sign, m24[23] ? re[7:0] : 8'd0, m24[22:0]};
      end
      default: if (out_ready) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sign <= 1'b0;
      exp_q <= 9'd0;
      mant <= 28'd0;
      out_float <= 32'd0;
      out_inexact <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_n;
      sign <= sign_n;
      exp_q <= exp_n;
      mant <= mant_n;
      out_float <= float_n;
      out_inexact <= inexact_n;
      out_overflow <= overflow_n;
    end
endmodule

// File: tb/tb_fp32_normalize_round.sv
// tb_fp32_normalize_round: random and directed checks of fp32_normalize_round against an exact-value rounding model.
module tb_fp32_normalize_round;
  localparam int STEP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
  logic [7:0] in_exp = 8'd0;
  logic [27:0] in_mant = 28'd0;
  logic in_ready, out_valid, out_inexact, out_overflow;
  logic [31:0] out_float;
  int total = 0, bad = 0;
  logic expect_valid = 1'b0;
  logic [31:0] e_f;
  logic e_ix, e_ov;

  fp32_normalize_round #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_float(out_float),
    .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Exact value is mant * 2^(exp-127-26); round that value directly to a 24-bit significand.
  task automatic model(input logic s, input int e, input logic [27:0] m,
                       output logic [31:0] f, output logic ix, output logic ov);
    longint mm, q, rem, half;
    int p, ex, h;
    f = {s, 31'd0}; ix = 1'b0; ov = 1'b0;
    if (m == 28'd0) return;
    mm = longint'(m);
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    ex = e + p - 26;
    if (ex < 1) ex = 1;
    h = 26 + ex - e;
    if (h >= 23) begin
      q = mm >> (h - 23);
      rem = mm - (q << (h - 23));
      half = (h > 23) ? (longint'(1) << (h - 24)) : 0;
    end else begin
      q = mm << (23 - h);
      rem = 0;
      half = 0;
    end
    ix = rem != 0;
    if (rem > half || (rem == half && rem != 0 && q[0])) q++;
    if (q >= (longint'(1) << 24)) begin q = q >> 1; ex++; end
    if (ex >= 255) begin f = {s, 8'hFF, 23'd0}; ov = 1'b1; end
    else f = {s, q[23] ? 8'(ex) : 8'd0, q[22:0]};
  endtask

  function automatic int lat_model(input int e, input logic [27:0] m, input int step);
    int p, n, c;
    if (m == 28'd0) return 1;
    if (m[27] || m[26]) return 2;
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    n = 26 - p;
    if (n > e - 1) n = e - 1;
    c = (n + step - 1) / step;
    if (c < 1) c = 1;
    return 2 + c;
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (out_valid && expect_valid) begin
      chk("out_float", out_float, e_f);
      chk("out_inexact", 32'(out_inexact), 32'(e_ix));
      chk("out_overflow", 32'(out_overflow), 32'(e_ov));
    end else if (out_valid) chk("unexpected_valid", 32'(out_valid), 32'd0);
  end

  task automatic run(input logic s, input logic [7:0] e, input logic [27:0] m, input int hold);
    int lat;
    logic [31:0] f;
    logic ix, ov;
    model(s, int'(e), m, f, ix, ov);
    e_f = f; e_ix = ix; e_ov = ov;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mant = 28'($urandom); in_exp = 8'($urandom); in_sign = 1'($urandom);
    expect_valid = 1'b1;
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      in_valid = 1'($urandom);
      lat++;
      if (lat > 60) break;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(lat_model(int'(e), m, STEP)));
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    expect_valid = 1'b0;
    @(negedge clk);
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] f;
    logic ix, ov;
    model(1'b0, 127, 28'h8000000, f, ix, ov); chk("pin_one_plus_one", f, 32'h40000000);
    model(1'b0, 127, 28'h0000008, f, ix, ov); chk("pin_cancel", f, 32'h34000000);
    model(1'b0, 127, 28'h4000004, f, ix, ov); chk("pin_tie_even", {f[31:1], ix}, {31'h1FC00000, 1'b1});
    model(1'b0, 127, 28'h400000C, f, ix, ov); chk("pin_tie_up", f, 32'h3F800002);
    model(1'b0, 254, 28'h7FFFFFC, f, ix, ov); chk("pin_overflow", {f[31:2], ix, ov}, {30'h1FE00000, 2'b11});
    model(1'b1, 5, 28'h0, f, ix, ov); chk("pin_neg_zero", f, 32'h80000000);
    model(1'b0, 1, 28'h0000008, f, ix, ov); chk("pin_denorm", f, 32'h00000001);
    chk("pin_lat_step4", 32'(lat_model(127, 28'h8, 4)), 32'd8);
    chk("pin_lat_step1", 32'(lat_model(127, 28'h8, 1)), 32'd25);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_float", out_float, 32'd0);
    chk("rst_flags", {30'd0, out_inexact, out_overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 8'd127, 28'h8000000, 0);
    run(1'b0, 8'd127, 28'h0000008, 0);
    run(1'b0, 8'd127, 28'h4000004, 1);
    run(1'b0, 8'd127, 28'h400000C, 0);
    run(1'b0, 8'd254, 28'h7FFFFFC, 2);
    run(1'b1, 8'd77, 28'h0, 0);
    run(1'b0, 8'd1, 28'h0000008, 0);
    run(1'b1, 8'd3, 28'h0000F00, 0);
    run(1'b0, 8'd254, 28'hFFFFFFF, 0);
    run(1'b1, 8'd100, 28'h3FFFFFF, 5);
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0000008; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_valid", 32'(out_valid), 32'd0);
    chk("midop_rst_ready", 32'(in_ready), 32'd1);
    chk("midop_rst_float", out_float, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midop_no_result", 32'(out_valid), 32'd0);
    for (int n = 0; n < 200; n++) begin
      logic [7:0] e;
      logic [27:0] m;
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 10)) : 8'($urandom_range(1, 254));
      m = 28'($urandom) >> $urandom_range(0, 28);
      run(1'($urandom), e, m, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
